// File: rtl/event_ack_ctrl.sv
// Event/ack flow controller: primes the frame-buffer slots, forwards completed events to the
// host, and turns host completions or readout timeouts into acks, nacks and drops.
module event_ack_ctrl #(
   parameter int NBUF      = 4,
   parameter int TIMEOUT   = 50000,
   parameter int MAX_RETRY = 3
) (
   input  logic        aclk,
   input  logic        reset_i,
   input  logic [31:0] s_event_tdata,
   input  logic        s_event_tvalid,
   output logic        s_event_tready,
   output logic [31:0] m_rd_tdata,
   output logic        m_rd_tvalid,
   input  logic        m_rd_tready,
   input  logic [12:0] s_cmpl_tdata,
   input  logic        s_cmpl_tvalid,
   output logic        s_cmpl_tready,
   output logic [15:0] m_ack_tdata,
   output logic        m_ack_tvalid,
   input  logic        m_ack_tready,
   output logic [31:0] m_nack_tdata,
   output logic        m_nack_tvalid,
   input  logic        m_nack_tready,
   output logic [3:0]  pending_o,
   output logic [15:0] drop_count_o,
   output logic        err_o
);
   localparam int PW = (NBUF > 2) ? $clog2(NBUF) : 1;
   localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [0:0] ST_PRIME = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [3:0]    prime_idx_q, prime_idx_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [3:0]    count_q, count_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [15:0]   drop_q, drop_d;
   logic          err_q, err_d;
   logic          rd_valid_q, rd_valid_d, ack_valid_q, ack_valid_d, nack_valid_q, nack_valid_d;
   logic [31:0]   rd_data_q, rd_data_d, nack_data_q, nack_data_d;
   logic [15:0]   ack_data_q, ack_data_d;

   logic [11:0]   ent_addr [NBUF];
   logic [19:0]   ent_len [NBUF];
   logic [RW-1:0] ent_retry [NBUF];
   logic          ent_rwait [NBUF];

   logic [11:0]   head_addr;
   logic [19:0]   head_len;
   logic [RW-1:0] head_retry;
   logic          head_rwait, run, nonempty, full, rd_free, ack_free, nack_free;
   logic          resend_match, ev_fire, push, resend_fwd, cmpl_fire, cmpl_hit, cmpl_err;
   logic          expire, exp_fire, retry_go, do_nack, do_drop, do_okack, pop, prime_load;

   assign head_addr  = ent_addr[rd_ptr_q];
   assign head_len   = ent_len[rd_ptr_q];
   assign head_retry = ent_retry[rd_ptr_q];
   assign head_rwait = ent_rwait[rd_ptr_q];

   assign run       = (state_q == ST_RUN);
   assign nonempty  = (count_q != 4'd0);
   assign full      = (count_q == 4'(NBUF));
   assign rd_free   = !rd_valid_q || m_rd_tready;
   assign ack_free  = !ack_valid_q || m_ack_tready;
   assign nack_free = !nack_valid_q || m_nack_tready;

   // A re-sent event for a nacked head is forwarded without taking a new slot.
   assign resend_match   = nonempty && head_rwait && (s_event_tdata[31:20] == head_addr);
   assign s_event_tready = run && rd_free && (!full || resend_match);
   assign ev_fire        = s_event_tvalid && s_event_tready;
   assign push           = ev_fire && !resend_match;
   assign resend_fwd     = ev_fire && resend_match;

   assign s_cmpl_tready = run && ack_free && nack_free;
   assign cmpl_fire     = s_cmpl_tvalid && s_cmpl_tready;
   assign cmpl_hit      = cmpl_fire && nonempty && (s_cmpl_tdata[11:0] == head_addr);
   assign cmpl_err      = cmpl_fire && !cmpl_hit;

   // The timer saturates at TIMEOUT so an expiry blocked by busy outputs stays pending.
   assign expire   = run && nonempty && !head_rwait && (timer_q == TW'(TIMEOUT));
   assign exp_fire = expire && ack_free && nack_free && !cmpl_fire;
   assign retry_go = (cmpl_hit && !s_cmpl_tdata[12]) || exp_fire;
   assign do_nack  = retry_go && (head_retry < RW'(MAX_RETRY));
   assign do_drop  = retry_go && !(head_retry < RW'(MAX_RETRY));
   assign do_okack = cmpl_hit && s_cmpl_tdata[12];
   assign pop      = do_okack || do_drop;

   assign prime_load = (state_q == ST_PRIME) && ack_free && (prime_idx_q < 4'(NBUF));

   for (genvar gi = 0; gi < NBUF; gi++) begin : g_ent
      logic [11:0]   addr_q, addr_d;
      logic [19:0]   len_q, len_d;
      logic [RW-1:0] retry_q, retry_d;
      logic          rwait_q, rwait_d;

      always_comb begin
         addr_d  = addr_q;
         len_d   = len_q;
         retry_d = retry_q;
         rwait_d = rwait_q;
         if (push && (wr_ptr_q == PW'(gi))) begin
            addr_d  = s_event_tdata[31:20];
            len_d   = s_event_tdata[19:0];
            retry_d = '0;
            rwait_d = 1'b0;
         end else if (rd_ptr_q == PW'(gi)) begin
            if (do_nack) begin
               retry_d = retry_q + 1'b1;
               rwait_d = 1'b1;
            end else if (resend_fwd) begin
               rwait_d = 1'b0;
            end
         end
      end

      always_ff @(posedge aclk or posedge reset_i) begin
         if (reset_i) begin
            addr_q  <= '0;
            len_q   <= '0;
            retry_q <= '0;
            rwait_q <= 1'b0;
         end else begin
            addr_q  <= addr_d;
            len_q   <= len_d;
            retry_q <= retry_d;
            rwait_q <= rwait_d;
         end
      end

      assign ent_addr[gi]  = addr_q;
      assign ent_len[gi]   = len_q;
      assign ent_retry[gi] = retry_q;
      assign ent_rwait[gi] = rwait_q;
   end

   always_comb begin
      state_d = state_q;
      if ((state_q == ST_PRIME) && (prime_idx_q == 4'(NBUF)) && ack_valid_q && m_ack_tready)
         state_d = ST_RUN;
      prime_idx_d = prime_load ? prime_idx_q + 4'd1 : prime_idx_q;

      wr_ptr_d = wr_ptr_q;
      if (push) wr_ptr_d = (wr_ptr_q == PW'(NBUF - 1)) ? '0 : wr_ptr_q + 1'b1;
      rd_ptr_d = rd_ptr_q;
      if (pop) rd_ptr_d = (rd_ptr_q == PW'(NBUF - 1)) ? '0 : rd_ptr_q + 1'b1;
      count_d = count_q + {3'b000, push} - {3'b000, pop};

      timer_d = timer_q;
      if (pop || do_nack || resend_fwd)
         timer_d = '0;
      else if (nonempty && !head_rwait && (timer_q != TW'(TIMEOUT)))
         timer_d = timer_q + 1'b1;

      drop_d = (do_drop && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
      err_d  = err_q || cmpl_err;

      rd_valid_d = ev_fire || (rd_valid_q && !m_rd_tready);
      rd_data_d  = ev_fire ? s_event_tdata : rd_data_q;

      ack_valid_d = prime_load || pop || (ack_valid_q && !m_ack_tready);
      ack_data_d  = ack_data_q;
      if (prime_load)
         ack_data_d = {(prime_idx_q == 4'(NBUF - 1)), 3'b000, 8'd0, prime_idx_q};
      else if (pop)
         ack_data_d = {1'b1, 3'b000, head_addr};

      nack_valid_d = do_nack || (nack_valid_q && !m_nack_tready);
      nack_data_d  = do_nack ? {head_addr, head_len} : nack_data_q;
   end

   always_ff @(posedge aclk or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= ST_PRIME;
         prime_idx_q  <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         timer_q      <= '0;
         drop_q       <= '0;
         err_q        <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_data_q    <= '0;
         ack_valid_q  <= 1'b0;
         ack_data_q   <= '0;
         nack_valid_q <= 1'b0;
         nack_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         prime_idx_q  <= prime_idx_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         timer_q      <= timer_d;
         drop_q       <= drop_d;
         err_q        <= err_d;
         rd_valid_q   <= rd_valid_d;
         rd_data_q    <= rd_data_d;
         ack_valid_q  <= ack_valid_d;
         ack_data_q   <= ack_data_d;
         nack_valid_q <= nack_valid_d;
         nack_data_q  <= nack_data_d;
      end
   end

   assign m_rd_tvalid   = rd_valid_q;
   assign m_rd_tdata    = rd_data_q;
   assign m_ack_tvalid  = ack_valid_q;
   assign m_ack_tdata   = ack_data_q;
   assign m_nack_tvalid = nack_valid_q;
   assign m_nack_tdata  = nack_data_q;
   assign pending_o     = count_q;
   assign drop_count_o  = drop_q;
   assign err_o         = err_q;
endmodule

// File: doc/event_ack_ctrl.md
EVENT_ACK_CTRL -- requirements
Module: event_ack_ctrl

Interface
REQ-001 Parameter NBUF, default 4: number of frame-buffer slots primed and tracked (2..8).
REQ-002 Parameter TIMEOUT, default 50000: aclk cycles allowed for a readout completion.
REQ-003 Parameter MAX_RETRY, default 3: nacks issued per event before it is dropped.
REQ-004 aclk  in  1  sole clock; all logic is on its rising edge.
REQ-005 reset_i  in  1  asynchronous, active-high reset.
REQ-006 s_event_tdata/tvalid/tready  in/in/out  32/1/1  completed event from the frame buffer: [31:20] addr, [19:0] len.
REQ-007 m_rd_tdata/tvalid/tready  out/out/in  32/1/1  readout request to the host, a copy of the accepted event word.
REQ-008 s_cmpl_tdata/tvalid/tready  in/in/out  13/1/1  host completion: [12] ok, [11:0] addr.
REQ-009 m_ack_tdata/tvalid/tready  out/out/in  16/1/1  ack to the frame buffer: {allow, 3'b000, addr[11:0]}.
REQ-010 m_nack_tdata/tvalid/tready  out/out/in  32/1/1  nack to the frame buffer: {addr[11:0], len[19:0]}.
REQ-011 pending_o  out  4  number of outstanding entries.
REQ-012 drop_count_o  out  16  saturating count of dropped events.
REQ-013 err_o  out  1  sticky protocol error.

Function
REQ-014 States: PRIME, RUN.
- PRIME is entered on reset.
- PRIME issues NBUF acks in order with addr 0..NBUF-1.
- allow=0 on every priming ack except the last, which has allow=1.
- After the last priming ack handshakes, the state moves to RUN.
REQ-015 Every master output holds tdata/tvalid stable until its tready is seen (AXI4-Stream rules); each output is a single register stage.
REQ-016 Outstanding FIFO: depth NBUF, in order. Each entry holds {addr, len, retries[1:0..], resend_wait}.
REQ-017 s_event_tready=1 only in RUN, and only when m_rd is empty or draining this cycle, and the FIFO is not full or the event is a resend match.
REQ-018 Event acceptance:
- An accepted event loads m_rd_tdata with the same word; tvalid is asserted the next cycle.
- If the head is in resend_wait and the event addr equals the head addr, no push occurs; resend_wait clears and the head timer restarts.
- Otherwise the event is pushed.
REQ-019 Head timer:
- Counts aclk cycles while the FIFO is non-empty and the head is not in resend_wait.
- Restarts at 0 on every pop, every nack, and every resend forward.
- Expires when it reaches TIMEOUT.
REQ-020 s_cmpl_tready=1 in RUN when both m_ack and m_nack are empty or draining; otherwise 0.
REQ-021 Completion handling:
- Completion with ok=1 and addr == head addr: issue ack {1,000,addr} and pop.
- Completion with ok=0 and addr == head addr: take the retry path.
REQ-022 A completion whose addr differs from the head, or that arrives with the FIFO empty, is consumed, sets err_o, and changes nothing else.
REQ-023 Retry path:
- If head retries < MAX_RETRY: issue nack {addr,len}, increment retries, set resend_wait.
- Else: issue ack {1,000,addr}, pop, and increment drop_count_o (saturating at 0xFFFF).
REQ-024 A timer expiry takes the retry path only when the ack and nack outputs are free; otherwise it is held pending.
REQ-025 A completion and an expiry in the same cycle: the completion wins and the expiry is discarded.
REQ-026 A push and a pop in the same cycle: pending_o is unchanged.
REQ-027 A full FIFO backpressures s_event and drops nothing.
REQ-028 Widths: len passes through unmodified (20 bits); addr is 12 bits, with no arithmetic on it beyond comparison.

Reset
REQ-029 Reset values:
- All tvalid outputs 0; all tready outputs 0.
- FIFO empty, pending_o=0, timer=0.
- drop_count_o=0, err_o=0.
- State PRIME.
REQ-030 Assertion mid-transaction abandons any in-flight beats immediately. After release, priming restarts from addr 0.

Verification
REQ-031 Release reset with NBUF=4 and tready=1 -> m_ack emits 0x0000, 0x0001, 0x0002, 0x8003 in order, then nothing further.
REQ-032 Event 0x00000C80 -> m_rd 0x00000C80 one cycle after accept, pending_o=1; completion 0x1000 -> ack 0x8000, pending_o=0.
REQ-033 Event 0x00000C80, completion 0x0000 -> nack 0x00000C80. Re-send of 0x00000C80 -> m_rd forwarded with pending_o still 1. Completion 0x1000 -> ack 0x8000.
REQ-034 TIMEOUT=100, event 0x00100064 with no completion -> nacks 0x00100064 at timer expiry. Re-send each time -> three nacks total, then ack 0x8001 and drop_count_o=1.
REQ-035 Event with addr 2 pending, completion 0x1005 -> err_o=1, no ack or nack, pending_o=1. Also: hold m_ack_tready=0 during priming -> 0x0000 is held stable, no skip.
REQ-036 Assert reset_i while a nack is pending with tready=0 -> tvalid drops asynchronously. After release, the priming sequence repeats exactly as in REQ-031.
